// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared memory port, counts retired instructions and traps on illegal ops.
module multicycle_controller #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            old_pc_write,
  output logic            ir_write,
  output logic            adr_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      result_src,
  output logic            retire,
  output logic            trap,
  output logic [XLEN-1:0] retire_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       old_pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
    logic       trap;
  } ctl_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int            TW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_wait_cnt;
  logic [XLEN-1:0] r_retire_count;
  ctl_t            w_ctl;
  ctl_t            w_ctl_out;
  logic            w_waiting;
  logic            w_timeout;
  logic            w_unused_funct7;

  // ALU function decode lives in the ALU decoder, not here.
  assign w_unused_funct7 = funct7_5;

  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR))
                     && !mem_ready;
  assign w_timeout = w_waiting && (r_wait_cnt == WAIT_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_next = r_state;
    w_ctl  = '0;
    case (r_state)
      S_FETCH: begin
        w_ctl.mem_read   = 1'b1;
        w_ctl.alu_src_b  = 2'd2;
        w_ctl.result_src = 2'd2;
        if (mem_ready) begin
          w_ctl.ir_write     = 1'b1;
          w_ctl.pc_write     = 1'b1;
          w_ctl.old_pc_write = 1'b1;
          w_next             = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        w_ctl.alu_src_a = 2'd1;
        w_ctl.alu_src_b = 2'd1;
        case (opcode)
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          default:           w_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        w_ctl.alu_src_a = 2'd2;
        w_ctl.alu_op    = 2'b10;
        w_next          = S_ALU_WB;
      end
      S_EXEC_I: begin
        w_ctl.alu_src_a = 2'd2;
        w_ctl.alu_src_b = 2'd1;
        w_ctl.alu_op    = 2'b10;
        w_next          = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.retire    = 1'b1;
        w_next          = S_FETCH;
      end
      S_MEM_ADDR: begin
        w_ctl.alu_src_a = 2'd2;
        w_ctl.alu_src_b = 2'd1;
        w_next          = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_ctl.adr_src  = 1'b1;
        w_ctl.mem_read = 1'b1;
        if (mem_ready)      w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEM_WB: begin
        w_ctl.result_src = 2'd1;
        w_ctl.reg_write  = 1'b1;
        w_ctl.retire     = 1'b1;
        w_next           = S_FETCH;
      end
      S_MEM_WR: begin
        w_ctl.adr_src   = 1'b1;
        w_ctl.mem_write = 1'b1;
        if (mem_ready) begin
          w_ctl.retire = 1'b1;
          w_next       = S_FETCH;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_BRANCH: begin
        w_ctl.alu_src_a = 2'd2;
        w_ctl.alu_op    = 2'b01;
        // Only BEQ/BNE are supported; funct3[0] inverts the zero test.
        if (funct3[2:1] == 2'b00) begin
          w_ctl.pc_write = zero ^ funct3[0];
          w_ctl.retire   = 1'b1;
          w_next         = S_FETCH;
        end else begin
          w_next = S_TRAP;
        end
      end
      S_JAL: begin
        w_ctl.alu_src_a = 2'd1;
        w_ctl.alu_src_b = 2'd2;
        w_ctl.pc_write  = 1'b1;
        w_next          = S_ALU_WB;
      end
      S_TRAP: begin
        w_ctl.trap = 1'b1;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase
  end

  // Strobes are forced low while reset is held so an aborted access writes nothing.
  assign w_ctl_out = reset ? w_ctl : '0;

  assign pc_write     = w_ctl_out.pc_write;
  assign old_pc_write = w_ctl_out.old_pc_write;
  assign ir_write     = w_ctl_out.ir_write;
  assign adr_src      = w_ctl_out.adr_src;
  assign mem_read     = w_ctl_out.mem_read;
  assign mem_write    = w_ctl_out.mem_write;
  assign reg_write    = w_ctl_out.reg_write;
  assign alu_src_a    = w_ctl_out.alu_src_a;
  assign alu_src_b    = w_ctl_out.alu_src_b;
  assign alu_op       = w_ctl_out.alu_op;
  assign result_src   = w_ctl_out.result_src;
  assign retire       = w_ctl_out.retire;
  assign trap         = w_ctl_out.trap;
  assign retire_count = r_retire_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_FETCH;
      r_wait_cnt     <= '0;
      r_retire_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next;
      if (w_next != r_state) r_wait_cnt <= '0;
      else if (w_waiting)    r_wait_cnt <= r_wait_cnt + TW'(1);
      if (w_ctl.retire) r_retire_count <= r_retire_count + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each instruction is expanded from the step rules into a
// queue of expected per-cycle control vectors, then applied and compared.
module tb_multicycle_controller;

  localparam int TB_XLEN    = 8;
  localparam int TB_TIMEOUT = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic       pc_write;
    logic       old_pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
    logic       trap;
  } ctl_t;

  typedef struct packed {
    logic ready;
    ctl_t exp;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7_5 = 1'b0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;

  logic pc_write, old_pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic retire, trap;
  logic [TB_XLEN-1:0] retire_count;

  ctl_t obs;
  assign obs = {pc_write, old_pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, retire, trap};

  int n_vec  = 0;
  int n_fail = 0;
  logic [TB_XLEN-1:0] model_cnt = '0;
  step_t plan[$];

  multicycle_controller #(.XLEN(TB_XLEN), .MEM_TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .old_pc_write(old_pc_write),
    .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .retire(retire), .trap(trap), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end expected end of run");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Expected control vectors for each step, taken from the step descriptions.
  function automatic ctl_t vsel(input int a, input int b, input int op, input int rs);
    ctl_t c = '0;
    c.alu_src_a  = 2'(a);
    c.alu_src_b  = 2'(b);
    c.alu_op     = 2'(op);
    c.result_src = 2'(rs);
    return c;
  endfunction

  function automatic ctl_t v_wait(input int kind, input logic rdy);
    ctl_t c = '0;
    if (kind == 0) begin
      c = vsel(0, 2, 0, 2);
      c.mem_read = 1'b1;
      c.ir_write = rdy;
      c.pc_write = rdy;
      c.old_pc_write = rdy;
    end else if (kind == 1) begin
      c.adr_src  = 1'b1;
      c.mem_read = 1'b1;
    end else begin
      c.adr_src   = 1'b1;
      c.mem_write = 1'b1;
      c.retire    = rdy;
    end
    return c;
  endfunction

  function automatic ctl_t v_wb(input int rs);
    ctl_t c = vsel(0, 0, 0, rs);
    c.reg_write = 1'b1;
    c.retire    = 1'b1;
    return c;
  endfunction

  function automatic ctl_t v_branch(input logic pcw, input logic ret);
    ctl_t c = vsel(2, 0, 1, 0);
    c.pc_write = pcw;
    c.retire   = ret;
    return c;
  endfunction

  function automatic ctl_t v_jal();
    ctl_t c = vsel(1, 2, 0, 0);
    c.pc_write = 1'b1;
    return c;
  endfunction

  function automatic ctl_t v_trap();
    ctl_t c = '0;
    c.trap = 1'b1;
    return c;
  endfunction

  // Steps that do not wait on memory see random mem_ready, which must be ignored.
  task automatic push_any(input ctl_t e);
    plan.push_back({1'($urandom_range(0, 1)), e});
  endtask

  task automatic add_wait(input int kind, input int w, output bit trapped);
    int n = (w < TB_TIMEOUT) ? w : TB_TIMEOUT;
    for (int i = 0; i < n; i++) plan.push_back({1'b0, v_wait(kind, 1'b0)});
    trapped = (w >= TB_TIMEOUT);
    if (!trapped) plan.push_back({1'b1, v_wait(kind, 1'b1)});
  endtask

  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input int fw, input int mw, input int n_trap, output bit trapped);
    bit t;
    plan.delete();
    add_wait(0, fw, t);
    if (!t) begin
      push_any(vsel(1, 1, 0, 0));
      case (op)
        OP_R:     begin push_any(vsel(2, 0, 2, 0)); push_any(v_wb(0)); end
        OP_I:     begin push_any(vsel(2, 1, 2, 0)); push_any(v_wb(0)); end
        OP_LOAD:  begin
          push_any(vsel(2, 1, 0, 0));
          add_wait(1, mw, t);
          if (!t) push_any(v_wb(1));
        end
        OP_STORE: begin push_any(vsel(2, 1, 0, 0)); add_wait(2, mw, t); end
        OP_BRANCH: begin
          if (f3 == 3'b000 || f3 == 3'b001) push_any(v_branch(z ^ f3[0], 1'b1));
          else begin push_any(v_branch(1'b0, 1'b0)); t = 1'b1; end
        end
        OP_JAL:   begin push_any(v_jal()); push_any(v_wb(0)); end
        default:  t = 1'b1;
      endcase
    end
    if (t) repeat (n_trap) push_any(v_trap());
    trapped = t;
  endtask

  task automatic run_plan(input string tag);
    foreach (plan[i]) begin
      mem_ready = plan[i].ready;
      #1;
      check($sformatf("%s.ctl[%0d]", tag, i), 32'(obs), 32'(plan[i].exp));
      check($sformatf("%s.cnt[%0d]", tag, i), 32'(retire_count), 32'(model_cnt));
      if (plan[i].exp.retire) model_cnt = model_cnt + 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("reset.ctl", 32'(obs), 32'd0);
    check("reset.cnt", 32'(retire_count), 32'd0);
    repeat (cyc) @(negedge clk);
    reset = 1'b1;
    model_cnt = '0;
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                          input int fw, input int mw, input int n_trap, input string tag);
    bit t;
    build(op, f3, z, fw, mw, n_trap, t);
    opcode = op;
    funct3 = f3;
    zero = z;
    funct7_5 = 1'($urandom_range(0, 1));
    run_plan(tag);
    if (t) do_reset(2);
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    int n_ret;
    @(negedge clk);
    do_reset(3);

    do_instr(OP_R, 3'b000, 1'b0, 0, 0, 3, "rtype");
    check("rtype.count", 32'(retire_count), 32'd1);

    do_instr(OP_LOAD, 3'b010, 1'b0, 0, 3, 3, "load_wait3");
    do_instr(OP_BRANCH, 3'b000, 1'b1, 0, 0, 3, "beq_taken");
    do_instr(OP_BRANCH, 3'b001, 1'b1, 0, 0, 3, "bne_not_taken");
    do_instr(OP_JAL, 3'b000, 1'b0, 0, 0, 3, "jal");
    do_instr(OP_STORE, 3'b010, 1'b0, 0, 3, 3, "store_wait3");
    do_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 20, "illegal_op");
    do_instr(OP_STORE, 3'b010, 1'b0, 0, 4, 3, "store_timeout");
    do_instr(OP_I, 3'b000, 1'b0, 4, 0, 3, "fetch_timeout");
    do_instr(OP_BRANCH, 3'b100, 1'b1, 0, 0, 3, "branch_bad_f3");

    // Abort a store mid-wait with an asynchronous reset pulse.
    do_instr(OP_R, 3'b000, 1'b0, 0, 0, 3, "pre_abort");
    plan.delete();
    opcode = OP_STORE;
    plan.push_back({1'b1, v_wait(0, 1'b1)});
    push_any(vsel(1, 1, 0, 0));
    push_any(vsel(2, 1, 0, 0));
    plan.push_back({1'b0, v_wait(2, 1'b0)});
    plan.push_back({1'b0, v_wait(2, 1'b0)});
    run_plan("abort");
    mem_ready = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("abort.ctl", 32'(obs), 32'd0);
    check("abort.cnt", 32'(retire_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_cnt = '0;
    do_instr(OP_I, 3'b000, 1'b0, 0, 0, 3, "after_abort");

    // Counter wrap: 256 more retires brings the 8-bit count back to its start.
    do_reset(1);
    n_ret = 0;
    for (int k = 0; k < 257; k++) begin
      do_instr(OP_BRANCH, 3'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 3, "wrap");
      n_ret++;
      if (n_ret == 256) check("wrap.zero", 32'(retire_count), 32'd0);
    end
    check("wrap.final", 32'(retire_count), 32'(TB_XLEN'(n_ret)));

    for (int k = 0; k < 200; k++) begin : rnd
      logic [6:0] opr;
      logic [2:0] f3;
      int cls;
      cls = int'($urandom_range(0, 7));
      f3 = 3'($urandom_range(0, 7));
      case (cls)
        0, 7: opr = OP_R;
        1: opr = OP_I;
        2: opr = OP_LOAD;
        3: opr = OP_STORE;
        4: begin
          opr = OP_BRANCH;
          if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
        end
        5: opr = OP_JAL;
        default: begin
          do opr = 7'($urandom);
          while (opr inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL});
        end
      endcase
      do_instr(opr, f3, 1'($urandom_range(0, 1)), rand_wait(), rand_wait(), 3, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
